mac_bnfifo_pipe: RTL and testbench
==================================

Name: mac_bnfifo_pipe

Overview:
Parametrised elastic pipeline between the conv MAC array and the batch-norm input FIFO. It carries NUM_LANES channel results per beat and rescales each wide MAC accumulator to DATA_WIDTH with round-half-up and saturation. It supports a configurable register depth and honours BN-FIFO backpressure with valid/ready, so no beat is dropped or duplicated. It also delays the BN-FIFO read strobe to stay aligned with the data path and reports sticky per-lane saturation flags.

Parameters:
NUM_LANES, 4, number of parallel channel lanes per beat
ACC_WIDTH, 32, signed MAC accumulator width per lane
DATA_WIDTH, 16, signed output width per lane (DATA_WIDTH <= ACC_WIDTH)
FRAC_SHIFT, 8, arithmetic right shift applied before saturation (0 = no shift, no rounding)
PIPE_STAGES, 2, number of register stages (>= 1); stage 0 performs the rescale

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
mac_valid_in  input  1  beat present on mac_acc_in
mac_ready_out  output  1  pipeline accepts a beat this cycle
mac_acc_in  input  NUM_LANES*ACC_WIDTH  signed accumulators; lane i in bits [i*ACC_WIDTH +: ACC_WIDTH]
bnfifo_rd_in  input  1  BN-FIFO read request from controller
bnfifo_full_in  input  1  BN FIFO full; downstream not ready
bnfifo_wr_out  output  1  write strobe into BN FIFO
bnfifo_rd_out  output  1  bnfifo_rd_in delayed by exactly PIPE_STAGES cycles
bnfifo_data_out  output  NUM_LANES*DATA_WIDTH  rescaled lanes, same lane packing
clr_sat_in  input  1  clear sticky saturation flags
sat_flag_out  output  NUM_LANES  sticky per-lane saturation indicator

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits = 0, all stage data = 0, rd delay line = 0, sat_flag_out = 0. After reset: bnfifo_wr_out = 0, bnfifo_rd_out = 0, bnfifo_data_out = 0. A reset mid-operation discards every in-flight beat.
- Rescale, per lane, in stage 0:
  - Compute t = acc + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0) in ACC_WIDTH+1 bits.
  - Arithmetic-shift t right by FRAC_SHIFT.
  - Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Exact ties round toward +inf: -1.5 -> -1, +1.5 -> +2.
- Saturation flag: when a lane clamps on an accepted beat, that lane's sat_flag_out bit is set the next cycle. The bit stays set until clr_sat_in. If clr_sat_in and a new saturation occur in the same cycle, set wins.
- Handshake:
  - A beat transfers when mac_valid_in && mac_ready_out.
  - Stage k captures when it is empty, or when its content advances this cycle.
  - The last stage advances when it is valid and !bnfifo_full_in. Bubbles collapse, so mac_ready_out = 1 while any stage can accept.
  - mac_ready_out is combinational from the valid bits and bnfifo_full_in. It has no combinational path from mac_valid_in.
- Output: bnfifo_wr_out = last_valid && !bnfifo_full_in (combinational). bnfifo_data_out = last-stage register, held stable while stalled.
- Latency and throughput:
  - Latency is PIPE_STAGES cycles from acceptance to bnfifo_wr_out with no stall.
  - Throughput is 1 beat/cycle.
  - Order is preserved, with no loss or duplication under any full pattern.
- Full pipeline: all stages valid and bnfifo_full_in = 1 -> mac_ready_out = 0. When full deasserts, mac_ready_out = 1 in that same cycle, and the last beat writes in that same cycle.
- bnfifo_rd_out is a plain PIPE_STAGES shift of bnfifo_rd_in. It is never stalled by backpressure.

Decomposition:
- Shared package mac_bnfifo_pkg:
  - rescale function: acc, shift -> {sat, value}.
  - Lane slicing helper constants.
  - Clamp limits derived from DATA_WIDTH.
- One sub-module, mac_bnfifo_stage: a single valid/data register with an advance/capture rule, instantiated PIPE_STAGES times via generate.

Test Plan:
- Rounding, defaults: lane0 acc=384 -> 2; 383 -> 1; -384 -> -1; -385 -> -2 (t=-257 floors to -2). Each appears 2 cycles after acceptance with bnfifo_wr_out=1.
- Saturation: lane2 acc=0x00800000 -> 32767 and sat_flag_out=4'b0100. Lane1 acc=-8388864 -> -32768 and bit1 set. Then clr_sat_in together with a new lane2 saturation -> bit2 stays 1 and bit1 clears.
- Backpressure: stream beats 1..10 with bnfifo_full_in=1 for cycles 3-7. Output sequence is exactly 1..10, no writes while full, and mac_ready_out=0 once both stages are filled.
- Read alignment: pulse bnfifo_rd_in at cycles 5 and 6 with full toggling -> bnfifo_rd_out at cycles 7 and 8 regardless.
- Reset mid-stream: rst for 1 cycle with 2 beats in flight -> no bnfifo_wr_out afterwards for those beats, all outputs 0, and sat_flag_out cleared.
- PIPE_STAGES=1, FRAC_SHIFT=0, DATA_WIDTH=ACC_WIDTH=16 -> data passes unmodified with latency 1 and sat_flag never sets.

Source files
------------

// File: rtl/mac_bnfifo_pkg.sv
// Shared helpers for the MAC -> BN-FIFO pipeline: lane slicing, clamp limits
// and the round-half-up / saturate rescale used by stage 0.
package mac_bnfifo_pkg;

  localparam int MAX_W = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t value;
  } rescale_t;

  localparam wide_t ONE = 64'sd1;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic wide_t clamp_max(input int dw);
    return (ONE <<< (dw - 1)) - ONE;
  endfunction

  function automatic wide_t clamp_min(input int dw);
    return -(ONE <<< (dw - 1));
  endfunction

  // The accumulator is sign-extended into 64 bits, so the rounding add never overflows.
  function automatic rescale_t rescale(input wide_t acc, input int shift, input int dw);
    rescale_t res;
    wide_t    t;
    wide_t    q;
    if (shift > 0) begin
      t = acc + (ONE <<< (shift - 1));
    end else begin
      t = acc;
    end
    q = t >>> shift;
    if (q > clamp_max(dw)) begin
      res.sat   = 1'b1;
      res.value = clamp_max(dw);
    end else if (q < clamp_min(dw)) begin
      res.sat   = 1'b1;
      res.value = clamp_min(dw);
    end else begin
      res.sat   = 1'b0;
      res.value = q;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_bnfifo_stage.sv
// One elastic register slot: loads when empty or when its current beat
// is taken downstream in the same cycle.
module mac_bnfifo_stage
  import mac_bnfifo_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_adv,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load  = !r_valid || i_adv;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Data only moves on a real beat so the output holds its last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {W{1'b0}};
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/mac_bnfifo_pipe.sv
// Elastic MAC -> BN-FIFO pipeline: per-lane rescale in stage 0, PIPE_STAGES
// register slots with collapsing bubbles, aligned read strobe, sticky saturation.
module mac_bnfifo_pipe
  import mac_bnfifo_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_SHIFT  = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mac_valid_in,
  output logic                            mac_ready_out,
  input  logic [NUM_LANES*ACC_WIDTH-1:0]  mac_acc_in,
  input  logic                            bnfifo_rd_in,
  input  logic                            bnfifo_full_in,
  output logic                            bnfifo_wr_out,
  output logic                            bnfifo_rd_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0] bnfifo_data_out,
  input  logic                            clr_sat_in,
  output logic [NUM_LANES-1:0]            sat_flag_out
);

  localparam int DW = NUM_LANES * DATA_WIDTH;

  logic [DW-1:0]          w_resc;
  logic [NUM_LANES-1:0]   w_sat;
  logic                   w_accept;
  logic                   w_valid [0:PIPE_STAGES];
  logic                   w_ready [0:PIPE_STAGES];
  logic [DW-1:0]          w_data  [0:PIPE_STAGES];
  logic [NUM_LANES-1:0]   r_sat;
  logic [PIPE_STAGES-1:0] r_rd_dly;

  // Per-lane rescale of the incoming accumulators.
  always_comb begin : rescale_lanes
    wide_t    w_acc_ext;
    rescale_t w_res;
    w_resc    = {DW{1'b0}};
    w_sat     = {NUM_LANES{1'b0}};
    w_acc_ext = {MAX_W{1'b0}};
    w_res     = {1'b0, {MAX_W{1'b0}}};
    for (int i = 0; i < NUM_LANES; i++) begin
      w_acc_ext = wide_t'($signed(mac_acc_in[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH]));
      w_res     = rescale(w_acc_ext, FRAC_SHIFT, DATA_WIDTH);
      w_resc[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = w_res.value[DATA_WIDTH-1:0];
      w_sat[i]  = w_res.sat;
    end
  end

  // Ready ripples back from the FIFO through the valid bits, never from mac_valid_in.
  assign w_valid[0]           = mac_valid_in;
  assign w_data[0]            = w_resc;
  assign w_ready[PIPE_STAGES] = !bnfifo_full_in;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    mac_bnfifo_stage #(.W(DW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_adv   (w_ready[k+1]),
      .o_ready (w_ready[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1])
    );
  end

  assign mac_ready_out   = w_ready[0];
  assign w_accept        = mac_valid_in && w_ready[0];
  assign bnfifo_wr_out   = w_valid[PIPE_STAGES] && !bnfifo_full_in;
  assign bnfifo_data_out = w_data[PIPE_STAGES];
  assign sat_flag_out    = r_sat;
  assign bnfifo_rd_out   = r_rd_dly[PIPE_STAGES-1];

  // Sticky saturation: a new clamp on an accepted beat wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= {NUM_LANES{1'b0}};
    end else begin
      r_sat <= (r_sat & ~{NUM_LANES{clr_sat_in}}) | (w_sat & {NUM_LANES{w_accept}});
    end
  end

  // Read strobe delay line, free-running regardless of backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_dly <= {PIPE_STAGES{1'b0}};
    end else begin
      r_rd_dly[0] <= bnfifo_rd_in;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r_rd_dly[k] <= r_rd_dly[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mac_bnfifo_pipe.sv
// Scoreboard bench for mac_bnfifo_pipe: default build plus a pass-through
// build (PIPE_STAGES=1, FRAC_SHIFT=0, 16-bit lanes).
module tb_mac_bnfifo_pipe;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         mac_valid_in;
  logic         mac_ready_out;
  logic [127:0] mac_acc_in;
  logic         bnfifo_rd_in;
  logic         bnfifo_full_in;
  logic         bnfifo_wr_out;
  logic         bnfifo_rd_out;
  logic [63:0]  bnfifo_data_out;
  logic         clr_sat_in;
  logic [3:0]   sat_flag_out;

  logic         b_valid;
  logic         b_ready;
  logic [63:0]  b_acc;
  logic         b_wr;
  logic         b_rd_out;
  logic [63:0]  b_data;
  logic [3:0]   b_sat;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   full_lo  = -10;
  int   full_hi  = -10;
  int   rd_a     = -10;
  int   rd_b     = -10;
  int   bp_chk   = -10;
  bit   rd_chk_en = 1'b0;
  exp_t sb_q[$];
  exp_t sb2_q[$];

  always #5 clk = ~clk;

  mac_bnfifo_pipe dut (
    .clk             (clk),
    .rst             (rst),
    .mac_valid_in    (mac_valid_in),
    .mac_ready_out   (mac_ready_out),
    .mac_acc_in      (mac_acc_in),
    .bnfifo_rd_in    (bnfifo_rd_in),
    .bnfifo_full_in  (bnfifo_full_in),
    .bnfifo_wr_out   (bnfifo_wr_out),
    .bnfifo_rd_out   (bnfifo_rd_out),
    .bnfifo_data_out (bnfifo_data_out),
    .clr_sat_in      (clr_sat_in),
    .sat_flag_out    (sat_flag_out)
  );

  mac_bnfifo_pipe #(
    .NUM_LANES(4), .ACC_WIDTH(16), .DATA_WIDTH(16), .FRAC_SHIFT(0), .PIPE_STAGES(1)
  ) dut1 (
    .clk             (clk),
    .rst             (rst),
    .mac_valid_in    (b_valid),
    .mac_ready_out   (b_ready),
    .mac_acc_in      (b_acc),
    .bnfifo_rd_in    (1'b0),
    .bnfifo_full_in  (1'b0),
    .bnfifo_wr_out   (b_wr),
    .bnfifo_rd_out   (b_rd_out),
    .bnfifo_data_out (b_data),
    .clr_sat_in      (1'b0),
    .sat_flag_out    (b_sat)
  );

  function automatic logic [127:0] acc4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [63:0] dat4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bnfifo_full_in = (cyc >= full_lo) && (cyc <= full_hi);
    bnfifo_rd_in   = (cyc == rd_a) || (cyc == rd_b);
    #1;
  endtask

  task automatic set_full(input int lo, input int hi);
    full_lo = lo;
    full_hi = hi;
    bnfifo_full_in = (cyc >= full_lo) && (cyc <= full_hi);
    #1;
  endtask

  task automatic send(input logic [127:0] acc, input logic [63:0] exp, input bit chk_lat);
    int guard;
    guard = 0;
    mac_valid_in = 1'b1;
    mac_acc_in   = acc;
    while (!mac_ready_out && guard < 50) begin
      tick();
      guard++;
    end
    if (!mac_ready_out) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=ready_high (cycle %0d)", cyc);
    end else begin
      sb_q.push_back('{exp, chk_lat ? cyc + 2 : -1});
    end
    tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    mac_valid_in = 1'b0;
    while (sb_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor for the default build.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst) begin
      if (bnfifo_wr_out) begin
        chk("wr_while_full", 64'(bnfifo_full_in), 64'd0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h required=no_write (cycle %0d)", bnfifo_data_out, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("data", bnfifo_data_out, e.data);
          if (e.cyc >= 0) chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (rd_chk_en) chk("rd_out", 64'(bnfifo_rd_out), 64'((cyc == rd_a + 2) || (cyc == rd_b + 2)));
      if (cyc == bp_chk) chk("ready_when_full", 64'(mac_ready_out), 64'd0);
    end
  end

  // Monitor for the pass-through build.
  always @(negedge clk) begin : mon_pass
    exp_t e;
    if (!rst && b_wr) begin
      chk("pass_sat", 64'(b_sat), 64'd0);
      chk("pass_rd", 64'(b_rd_out), 64'd0);
      if (sb2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pass_unexpected_write actual=%h required=no_write (cycle %0d)", b_data, cyc);
      end else begin
        e = sb2_q.pop_front();
        chk("pass_data", b_data, e.data);
        chk("pass_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    rst = 1'b1;
    mac_valid_in = 1'b0;
    mac_acc_in = 128'd0;
    bnfifo_rd_in = 1'b0;
    bnfifo_full_in = 1'b0;
    clr_sat_in = 1'b0;
    b_valid = 1'b0;
    b_acc = 64'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_wr", 64'(bnfifo_wr_out), 64'd0);
    chk("rst_rd", 64'(bnfifo_rd_out), 64'd0);
    chk("rst_data", bnfifo_data_out, 64'd0);
    chk("rst_sat", 64'(sat_flag_out), 64'd0);
    chk("rst_ready", 64'(mac_ready_out), 64'd1);

    // Rounding at default FRAC_SHIFT=8.
    send(acc4(384, 0, 0, 0), dat4(2, 0, 0, 0), 1'b1);
    send(acc4(383, 0, 0, 0), dat4(1, 0, 0, 0), 1'b1);
    send(acc4(-384, 0, 0, 0), dat4(-1, 0, 0, 0), 1'b1);
    send(acc4(-385, 0, 0, 0), dat4(-2, 0, 0, 0), 1'b1);
    drain();
    chk("no_sat_after_rounding", 64'(sat_flag_out), 64'd0);

    // Saturation and sticky flags.
    send(acc4(0, 0, 32'h0080_0000, 0), dat4(0, 0, 32767, 0), 1'b1);
    mac_valid_in = 1'b0;
    chk("sat_lane2", 64'(sat_flag_out), 64'h4);
    send(acc4(0, -8388864, 0, 0), dat4(0, -32768, 0, 0), 1'b1);
    mac_valid_in = 1'b0;
    chk("sat_lane1", 64'(sat_flag_out), 64'h6);
    clr_sat_in = 1'b1;
    send(acc4(0, 0, 32'h0100_0000, 0), dat4(0, 0, 32767, 0), 1'b1);
    clr_sat_in = 1'b0;
    mac_valid_in = 1'b0;
    chk("sat_clr_vs_set", 64'(sat_flag_out), 64'h4);
    drain();
    clr_sat_in = 1'b1;
    tick();
    clr_sat_in = 1'b0;
    chk("sat_cleared", 64'(sat_flag_out), 64'd0);

    // Backpressure stream 1..10 with read-strobe alignment.
    c0 = cyc;
    set_full(c0 + 3, c0 + 7);
    rd_a = c0 + 5;
    rd_b = c0 + 6;
    bp_chk = c0 + 4;
    rd_chk_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      send(acc4(k * 256, 0, 0, -k * 256), dat4(k, 0, 0, -k), 1'b0);
    end
    drain();
    while (cyc < c0 + 12) tick();
    rd_chk_en = 1'b0;
    rd_a = -10;
    rd_b = -10;
    bp_chk = -10;
    set_full(-10, -10);

    // Reset with two beats held in flight.
    c0 = cyc;
    set_full(c0, c0 + 20);
    send(acc4(32'h0080_0000, 0, 0, 0), dat4(32767, 0, 0, 0), 1'b0);
    send(acc4(256, 0, 0, 0), dat4(1, 0, 0, 0), 1'b0);
    mac_valid_in = 1'b0;
    chk("sat_before_reset", 64'(sat_flag_out), 64'h1);
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    set_full(-10, -10);
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_wr", 64'(bnfifo_wr_out), 64'd0);
      chk("post_rst_data", bnfifo_data_out, 64'd0);
      chk("post_rst_sat", 64'(sat_flag_out), 64'd0);
      chk("post_rst_rd", 64'(bnfifo_rd_out), 64'd0);
      tick();
    end

    // Pass-through build: unmodified data, latency 1.
    for (int k = 0; k < 4; k++) begin
      logic [63:0] v;
      case (k)
        0: v = 64'h8000_7FFF_0001_FFFF;
        1: v = 64'h1234_5678_9ABC_DEF0;
        2: v = 64'h7FFF_8000_0000_8001;
        default: v = 64'hFFFF_0000_FFFF_0000;
      endcase
      b_valid = 1'b1;
      b_acc = v;
      chk("pass_ready", 64'(b_ready), 64'd1);
      sb2_q.push_back('{v, cyc + 1});
      tick();
    end
    b_valid = 1'b0;
    repeat (3) tick();
    chk("pass_drain_left", 64'(sb2_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
